// File: rtl/add_arb_pkg.sv
// Shared constants for the add_arbiter slice: state encoding, id width helper
// and the adder width.
package add_arb_pkg;

    localparam int DEFAULT_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } arb_state_e;

    // Requester-id width; at least one bit so a 1-wide port always exists.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward (mod NREQ) and
// returns the first pending request as one-hot grant plus encoded index.
module rr_pick
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    // Priority scan; the previous winner is visited last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDW'(cand);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/sxtfBitAdder.sv
// Shared 64-bit adder with carry-in and carry-out.
module sxtfBitAdder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 64-bit adder between NREQ requesters, with
// per-requester carry chaining and a single registered result slot.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*W-1:0]     req_a,
    input  logic [NREQ*W-1:0]     req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [W-1:0]          res_sum,
    output logic                  res_cout,
    output logic [idw(NREQ)-1:0]  res_id
);

    localparam int IDW = idw(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [IDW-1:0]   id_q, id_d;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             slot_free;
    logic             accept;
    logic [W-1:0]     add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    sxtfBitAdder u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Grant and operand mux; grants are suppressed while reset is asserted.
    always_comb begin
        slot_free = (state_q == ST_IDLE) || res_ready;
        if (slot_free && !rst) begin
            req_ready = pick_gnt;
            accept    = pick_any;
        end else begin
            req_ready = '0;
            accept    = 1'b0;
        end
        add_a   = req_a[int'(pick_idx)*W +: W];
        add_b   = req_b[int'(pick_idx)*W +: W];
        add_cin = req_chain[pick_idx] ? carry_q[pick_idx] : req_cin[pick_idx];
    end

    // Next-state logic for the result slot, carries and pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    state_d = ST_FULL;
                end else if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            sum_d             = add_sum;
            cout_d            = add_cout;
            id_d              = pick_idx;
            carry_d[pick_idx] = add_cout;
            ptr_d             = pick_idx;
        end else begin
            sum_d = sum_q;
        end
    end

    // State and result registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            carry_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter with hand-computed results.
module tb_add_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 64;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [1:0]        res_id;

    int num_checks = 0;
    int num_errors = 0;

    add_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic chain, input logic v);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_chain[i]    = chain;
        req_valid[i]    = v;
    endtask

    task automatic check_res(input string tag, input logic [63:0] sum, input logic cout, input int id);
        check_eq({tag, "_valid"}, 64'(res_valid), 64'd1);
        check_eq({tag, "_sum"}, res_sum, sum);
        check_eq({tag, "_cout"}, 64'(res_cout), 64'(cout));
        check_eq({tag, "_id"}, 64'(res_id), 64'(id));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        res_ready = 1'b1;

        // Reset: no grant even with all requests up.
        #2;
        req_valid = 4'b1111;
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_sum", res_sum, 64'd0);
        check_eq("rst_cout", 64'(res_cout), 64'd0);
        check_eq("rst_id", 64'(res_id), 64'd0);

        // Single add on requester 0.
        set_req(0, 64'd1, 64'd16, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("single_ready", 64'(req_ready), 64'b0001);
        check_eq("single_pre_valid", 64'(res_valid), 64'd0);
        tick();
        req_valid[0] = 1'b0;
        check_res("single", 64'd17, 1'b0, 0);
        tick();
        check_eq("single_drain", 64'(res_valid), 64'd0);

        // Overflow on requester 2.
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("ovf_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        check_res("ovf", 64'd2, 1'b1, 2);
        tick();

        // Chain on requester 1; requester 3 chains concurrently with carry 0.
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        tick();
        check_res("chain0", 64'd0, 1'b1, 1);
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
        set_req(3, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
        #1;
        check_eq("chain_ready3", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        check_res("chain3", 64'd0, 1'b0, 3);
        check_eq("chain_ready1", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        check_res("chain1", 64'd1, 1'b0, 1);
        tick();

        // Reset while a result is held.
        res_ready = 1'b0;
        set_req(0, 64'd5, 64'd6, 1'b0, 1'b0, 1'b1);
        tick();
        req_valid[0] = 1'b0;
        check_res("hold", 64'd11, 1'b0, 0);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(res_valid), 64'd0);
        check_eq("midrst_sum", res_sum, 64'd0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;

        // Round robin with all requesters; requester 2 chains on a cleared carry.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 64'(i), 64'h10, 1'b0, (i == 2), 1'b1);
        end
        #1;
        check_eq("rr_first_ready", 64'(req_ready), 64'b0001);
        begin
            int exp_id[5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) begin
                tick();
                check_res($sformatf("rr%0d", k), 64'(exp_id[k]) + 64'h10, 1'b0, exp_id[k]);
            end
        end

        // Backpressure for three cycles.
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
            tick();
            check_res($sformatf("bp%0d", k), 64'h10, 1'b0, 0);
        end
        res_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        check_res("bp_next", 64'h11, 1'b0, 1);
        tick();
        check_eq("final_drain", 64'(res_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
